// File: rtl/num_codec_pkg.sv
// Shared constants and state encoding for the digit<->seconds codec pair.
// The decoder imports the same limits so both sides agree on digit ranges.
package num_codec_pkg;

   localparam int NUM_W = 8;
   localparam int DIG_W = 4;
   localparam int POS_W = 2;

   localparam logic [DIG_W-1:0] MAX_MIN     = 4'd3;
   localparam logic [DIG_W-1:0] MAX_TEN     = 4'd5;
   localparam logic [DIG_W-1:0] MAX_ONE     = 4'd9;
   localparam logic [NUM_W-1:0] SEC_PER_MIN = 8'd60;
   localparam logic [NUM_W-1:0] SEC_PER_TEN = 8'd10;

   typedef enum logic [2:0] {
      S_MIN   = 3'd0,
      S_TEN   = 3'd1,
      S_ONE   = 3'd2,
      S_CALC1 = 3'd3,
      S_CALC2 = 3'd4
   } state_t;

   // Largest digit legal in the given entry position; unused outside entry.
   function automatic logic [DIG_W-1:0] digit_max(input state_t s);
      case (s)
         S_MIN:   digit_max = MAX_MIN;
         S_TEN:   digit_max = MAX_TEN;
         S_ONE:   digit_max = MAX_ONE;
         default: digit_max = '0;
      endcase
   endfunction

endpackage

// File: rtl/num_encoder_if.sv
// Digit-entry / result bus between the keypad logic and the encoder.
interface num_encoder_if;
   import num_codec_pkg::*;

   logic [DIG_W-1:0] digit_in;
   logic             digit_valid;
   logic             clear;
   logic [NUM_W-1:0] num;
   logic             num_valid;
   logic             err;
   logic             busy;
   logic [POS_W-1:0] pos;

   modport master (
      output digit_in, digit_valid, clear,
      input  num, num_valid, err, busy, pos
   );

   modport slave (
      input  digit_in, digit_valid, clear,
      output num, num_valid, err, busy, pos
   );

endinterface

// File: rtl/num_encoder.sv
// Three-digit M:SS entry to total-seconds encoder (0..239), two-cycle
// compute after the ones digit is accepted; result held until next entry.
module num_encoder
   import num_codec_pkg::*;
(
   input logic           clk,
   input logic           rst_n,
   num_encoder_if.slave  bus
);

   state_t state, nxt;

   logic [DIG_W-1:0] min_r, ten_r, one_r;
   logic [NUM_W-1:0] acc_r;
   logic [NUM_W-1:0] num_r;
   logic             num_valid_r;
   logic             err_r;

   logic             entry;
   logic             take;
   logic             in_range;
   logic             accept;
   logic             bad;

   logic [NUM_W-1:0] m_x, t_x, o_x;
   logic [NUM_W-1:0] min_sec, ten_sec;

   assign entry    = (state == S_MIN) || (state == S_TEN) || (state == S_ONE);
   // clear dominates a simultaneous digit: it is neither latched nor flagged.
   assign take     = bus.digit_valid && !bus.clear && entry;
   assign in_range = (bus.digit_in <= digit_max(state));
   assign accept   = take && in_range;
   assign bad      = take && !in_range;

   assign m_x = {{(NUM_W-DIG_W){1'b0}}, min_r};
   assign t_x = {{(NUM_W-DIG_W){1'b0}}, ten_r};
   assign o_x = {{(NUM_W-DIG_W){1'b0}}, one_r};

   // x*60 = x*64 - x*4 and x*10 = x*8 + x*2; min_r <= 3 keeps x*64 in 8 bits.
   assign min_sec = (m_x << 6) - (m_x << 2);
   assign ten_sec = (t_x << 3) + (t_x << 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_MIN;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (bus.clear) begin
         nxt = S_MIN;
      end else begin
         case (state)
            S_MIN:   if (accept) nxt = S_TEN;
            S_TEN:   if (accept) nxt = S_ONE;
            S_ONE:   if (accept) nxt = S_CALC1;
            S_CALC1: nxt = S_CALC2;
            S_CALC2: nxt = S_MIN;
            default: nxt = S_MIN;
         endcase
      end
   end

   always_comb begin
      bus.busy = 1'b0;
      bus.pos  = 2'd0;
      case (state)
         S_MIN:   bus.pos = 2'd0;
         S_TEN:   bus.pos = 2'd1;
         S_ONE:   bus.pos = 2'd2;
         S_CALC1: begin bus.pos = 2'd3; bus.busy = 1'b1; end
         S_CALC2: begin bus.pos = 2'd3; bus.busy = 1'b1; end
         default: bus.pos = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_r       <= '0;
         ten_r       <= '0;
         one_r       <= '0;
         acc_r       <= '0;
         num_r       <= '0;
         num_valid_r <= 1'b0;
         err_r       <= 1'b0;
      end else if (bus.clear) begin
         // Abort the partial entry but keep the last published result.
         min_r       <= '0;
         ten_r       <= '0;
         one_r       <= '0;
         acc_r       <= '0;
         num_valid_r <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         err_r       <= bad;
         num_valid_r <= 1'b0;
         if (accept) begin
            case (state)
               S_MIN:   min_r <= bus.digit_in;
               S_TEN:   ten_r <= bus.digit_in;
               S_ONE:   one_r <= bus.digit_in;
               default: ;
            endcase
         end
         if (state == S_CALC1) acc_r <= min_sec + ten_sec;
         if (state == S_CALC2) begin
            num_r       <= acc_r + o_x;
            num_valid_r <= 1'b1;
         end
      end
   end

   assign bus.num       = num_r;
   assign bus.num_valid = num_valid_r;
   assign bus.err       = err_r;

endmodule

// File: tb/tb_num_encoder.sv
// Scoreboard bench for num_encoder: expected seconds are queued as the ones
// digit is driven and retired, with latency, when num_valid appears.
module tb_num_encoder;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_cmp;
   int   n_bad;

   typedef struct {
      int num;
      int due;
   } sb_t;

   sb_t sb[$];
   sb_t exp_e;

   num_encoder_if bif ();

   num_encoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Drive one cycle of inputs, sample #1 after the edge and check err.
   task automatic drive(input logic [3:0] d, input logic v, input logic c,
                        input logic exp_err, input string tag);
      bif.digit_in    = d;
      bif.digit_valid = v;
      bif.clear       = c;
      @(posedge clk);
      #1;
      chk({tag, "_err"}, {31'd0, bif.err}, {31'd0, exp_err});
      bif.digit_valid = 1'b0;
      bif.clear       = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic enter3(input int m, input int t, input int o, input string tag);
      sb_t e;
      drive(4'(m), 1'b1, 1'b0, 1'b0, {tag, "_m"});
      drive(4'(t), 1'b1, 1'b0, 1'b0, {tag, "_t"});
      drive(4'(o), 1'b1, 1'b0, 1'b0, {tag, "_o"});
      e.num = m * 60 + t * 10 + o;
      e.due = cyc + 2;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n && bif.num_valid) begin
         if (sb.size() == 0) begin
            chk("unexp_valid", 32'd1, 32'd0);
         end else begin
            exp_e = sb.pop_front();
            chk("num", {24'd0, bif.num}, exp_e.num);
            chk("latency", cyc, exp_e.due);
         end
      end
   end

   initial begin
      cyc   = 0;
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bif.digit_in    = '0;
      bif.digit_valid = 1'b0;
      bif.clear       = 1'b0;
      idle(3);
      chk("rst_num",  {24'd0, bif.num}, 0);
      chk("rst_nv",   {31'd0, bif.num_valid}, 0);
      chk("rst_err",  {31'd0, bif.err}, 0);
      chk("rst_busy", {31'd0, bif.busy}, 0);
      chk("rst_pos",  {30'd0, bif.pos}, 0);
      rst_n = 1'b1;
      idle(2);

      // 2:37 -> 157, busy exactly two cycles
      enter3(2, 3, 7, "e157");
      chk("busy_c1", {31'd0, bif.busy}, 1);
      chk("pos_c1",  {30'd0, bif.pos}, 3);
      idle(1);
      chk("busy_c2", {31'd0, bif.busy}, 1);
      idle(1);
      chk("busy_done", {31'd0, bif.busy}, 0);
      chk("pos_done",  {30'd0, bif.pos}, 0);
      idle(3);

      // boundary values; result holds afterwards
      enter3(0, 0, 0, "e0");
      idle(4);
      enter3(3, 5, 9, "e239");
      idle(6);
      chk("hold_239", {24'd0, bif.num}, 239);

      // out-of-range digits in each position
      drive(4'd4, 1'b1, 1'b0, 1'b1, "bad_min");
      chk("pos_after_bad_min", {30'd0, bif.pos}, 0);
      drive(4'd1, 1'b1, 1'b0, 1'b0, "ok_min");
      chk("pos_after_ok_min", {30'd0, bif.pos}, 1);
      drive(4'd6, 1'b1, 1'b0, 1'b1, "bad_ten");
      chk("pos_after_bad_ten", {30'd0, bif.pos}, 1);
      drive(4'd2, 1'b1, 1'b0, 1'b0, "ok_ten");
      drive(4'd12, 1'b1, 1'b0, 1'b1, "bad_one");
      chk("pos_after_bad_one", {30'd0, bif.pos}, 2);
      drive(4'd5, 1'b1, 1'b0, 1'b0, "ok_one");
      exp_e.num = 85;
      exp_e.due = cyc + 2;
      sb.push_back(exp_e);
      idle(5);

      // clear mid-entry, clear colliding with a digit, then a fresh entry
      drive(4'd1, 1'b1, 1'b0, 1'b0, "clr_m");
      drive(4'd4, 1'b1, 1'b0, 1'b0, "clr_t");
      drive(4'd9, 1'b1, 1'b1, 1'b0, "clr_hit");
      chk("pos_after_clr", {30'd0, bif.pos}, 0);
      drive(4'd7, 1'b1, 1'b1, 1'b0, "clr_bad_digit");
      enter3(0, 3, 0, "e30");
      idle(5);

      // clear during the final compute cycle cancels the update
      drive(4'd1, 1'b1, 1'b0, 1'b0, "c2_m");
      drive(4'd1, 1'b1, 1'b0, 1'b0, "c2_t");
      drive(4'd1, 1'b1, 1'b0, 1'b0, "c2_o");
      drive(4'd0, 1'b0, 1'b0, 1'b0, "c2_calc1");
      drive(4'd0, 1'b0, 1'b1, 1'b0, "c2_clear");
      idle(4);
      chk("num_after_cancel", {24'd0, bif.num}, 30);

      // digits during busy are ignored; next entry starts right after
      enter3(2, 0, 1, "e121");
      drive(4'd9, 1'b1, 1'b0, 1'b0, "busy_dig1");
      drive(4'd15, 1'b1, 1'b0, 1'b0, "busy_dig2");
      enter3(0, 1, 0, "e10");
      idle(5);

      // reset during compute aborts the entry immediately
      drive(4'd3, 1'b1, 1'b0, 1'b0, "r_m");
      drive(4'd0, 1'b1, 1'b0, 1'b0, "r_t");
      drive(4'd0, 1'b1, 1'b0, 1'b0, "r_o");
      rst_n = 1'b0;
      #1;
      chk("mid_rst_num",  {24'd0, bif.num}, 0);
      chk("mid_rst_busy", {31'd0, bif.busy}, 0);
      chk("mid_rst_pos",  {30'd0, bif.pos}, 0);
      chk("mid_rst_nv",   {31'd0, bif.num_valid}, 0);
      idle(2);
      rst_n = 1'b1;
      idle(5);
      chk("post_rst_num", {24'd0, bif.num}, 0);

      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
